sort_e2_merge: RTL and testbench

Second-stage top-5 merger that consumes the per-line candidate lists from the E1 sorter and keeps a running global top-5 across all lines of a frame. Each line delivers two descending-sorted 5-entry lists, low half and high half. Each entry is `{index[15:0], data[7:0]}` with signed int8 data. The block merges both lists with the held top-5 in five cycles, rewrites indices as global element numbers, and presents the final top-5 when the frame's last line has been merged.

---
 rtl/sort_e2_merge.sv | 211 +++++++++++++++++++++
 tb/tb_sort_e2_merge.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_e2_merge.sv
// sort_e2_merge - second-stage top-5 merger.
//
// Takes the two descending 5-entry candidate lists (low half and high half)
// that the E1 sorter produces for each line. Merges them with the running
// top-5 of the frame over five cycles, one output slot per cycle. Candidate
// indices are rewritten as global element numbers: {line, local position}.
// When the frame's last line has been merged, the result is presented on
// topk_out0..4 with a one-cycle topk_valid pulse, and the running top-5 is
// re-armed for the next frame.
//
// Ports
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   sorter_clr                synchronous clear, same effect as reset
//   E1L_sorter_out0..4        low-half candidates {index, data}, descending
//   E1H_sorter_out0..4        high-half candidates {index, data}, descending
//   E1_sort_en                one-cycle strobe, candidates valid
//   E1_last_sort              qualifies E1_sort_en: last line of the frame
//   E1_index_counter          line count, already incremented (line = cnt-1)
//   topk_out0..4              global top-5, descending
//   topk_valid                one-cycle strobe, topk_out* updated
//   topk_busy                 high while a merge is in progress
//   err_overrun               sticky: a strobe arrived while busy
module sort_e2_merge #(
    parameter int                    Data_Width  = 8,
    parameter int                    Index_Width = 16,
    parameter logic [Data_Width-1:0] MIN         = 8'h80
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst,
    input  logic                              sorter_clr,
    input  logic [Index_Width+Data_Width-1:0] E1L_sorter_out0,
    input  logic [Index_Width+Data_Width-1:0] E1L_sorter_out1,
    input  logic [Index_Width+Data_Width-1:0] E1L_sorter_out2,
    input  logic [Index_Width+Data_Width-1:0] E1L_sorter_out3,
    input  logic [Index_Width+Data_Width-1:0] E1L_sorter_out4,
    input  logic [Index_Width+Data_Width-1:0] E1H_sorter_out0,
    input  logic [Index_Width+Data_Width-1:0] E1H_sorter_out1,
    input  logic [Index_Width+Data_Width-1:0] E1H_sorter_out2,
    input  logic [Index_Width+Data_Width-1:0] E1H_sorter_out3,
    input  logic [Index_Width+Data_Width-1:0] E1H_sorter_out4,
    input  logic                              E1_sort_en,
    input  logic                              E1_last_sort,
    input  logic [Index_Width-1:0]            E1_index_counter,
    output logic [Index_Width+Data_Width-1:0] topk_out0,
    output logic [Index_Width+Data_Width-1:0] topk_out1,
    output logic [Index_Width+Data_Width-1:0] topk_out2,
    output logic [Index_Width+Data_Width-1:0] topk_out3,
    output logic [Index_Width+Data_Width-1:0] topk_out4,
    output logic                              topk_valid,
    output logic                              topk_busy,
    output logic                              err_overrun
);

    localparam int EW     = Index_Width + Data_Width;
    localparam int LINE_W = Index_Width - 5;
    localparam logic [EW-1:0] SENT = {{Index_Width{1'b1}}, MIN};

    typedef enum logic {IDLE, MERGE} state_t;
    typedef enum logic [1:0] {SEL_OLD, SEL_L, SEL_H} sel_t;

    state_t          state;
    logic   [EW-1:0] held  [5];
    logic   [EW-1:0] old_q [5];
    logic   [EW-1:0] lst_l [5];
    logic   [EW-1:0] lst_h [5];
    logic   [EW-1:0] topk_q[5];
    logic   [2:0]    p_o, p_l, p_h;
    logic   [2:0]    k;
    logic            last_q;

    logic   [EW-1:0] in_l [5];
    logic   [EW-1:0] in_h [5];

    assign in_l[0] = E1L_sorter_out0;
    assign in_l[1] = E1L_sorter_out1;
    assign in_l[2] = E1L_sorter_out2;
    assign in_l[3] = E1L_sorter_out3;
    assign in_l[4] = E1L_sorter_out4;
    assign in_h[0] = E1H_sorter_out0;
    assign in_h[1] = E1H_sorter_out1;
    assign in_h[2] = E1H_sorter_out2;
    assign in_h[3] = E1H_sorter_out3;
    assign in_h[4] = E1H_sorter_out4;

    assign topk_out0 = topk_q[0];
    assign topk_out1 = topk_q[1];
    assign topk_out2 = topk_q[2];
    assign topk_out3 = topk_q[3];
    assign topk_out4 = topk_q[4];

    // Line number wraps modulo 2^LINE_W; only local position bits [4:0]
    // of each candidate index are meaningful.
    logic [Index_Width-1:0] line_full;
    logic [LINE_W-1:0]      line_num;
    assign line_full = E1_index_counter - 1'b1;
    assign line_num  = line_full[LINE_W-1:0];

    logic unused_bits;
    always_comb begin
        unused_bits = ^line_full[Index_Width-1:LINE_W];
        for (int i = 0; i < 5; i++) begin
            unused_bits = unused_bits ^ (^in_l[i][EW-1:Data_Width+5])
                                      ^ (^in_h[i][EW-1:Data_Width+5]);
        end
    end

    function automatic logic [EW-1:0] globalize(input logic [EW-1:0] cand,
                                                 input logic [LINE_W-1:0] line);
        return {line, cand[Data_Width+4:Data_Width], cand[Data_Width-1:0]};
    endfunction

    // Head of each list; an exhausted list (pointer 5) presents the sentinel.
    logic [EW-1:0] head_o, head_l, head_h, sel_entry;
    logic signed [Data_Width-1:0] d_o, d_l, d_h;
    sel_t sel;

    always_comb begin
        head_o = SENT;
        head_l = SENT;
        head_h = SENT;
        for (int i = 0; i < 5; i++) begin
            if (p_o == 3'(i)) head_o = old_q[i];
            if (p_l == 3'(i)) head_l = lst_l[i];
            if (p_h == 3'(i)) head_h = lst_h[i];
        end
        d_o = signed'(head_o[Data_Width-1:0]);
        d_l = signed'(head_l[Data_Width-1:0]);
        d_h = signed'(head_h[Data_Width-1:0]);
        // >= gives ties to the earlier list: old over L, L over H.
        if (d_o >= d_l && d_o >= d_h) begin
            sel       = SEL_OLD;
            sel_entry = head_o;
        end else if (d_l >= d_h) begin
            sel       = SEL_L;
            sel_entry = head_l;
        end else begin
            sel       = SEL_H;
            sel_entry = head_h;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || sorter_clr) begin
            state       <= IDLE;
            p_o         <= '0;
            p_l         <= '0;
            p_h         <= '0;
            k           <= '0;
            last_q      <= 1'b0;
            topk_valid  <= 1'b0;
            topk_busy   <= 1'b0;
            err_overrun <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                held[i]   <= SENT;
                old_q[i]  <= SENT;
                lst_l[i]  <= SENT;
                lst_h[i]  <= SENT;
                topk_q[i] <= '0;
            end
        end else begin
            topk_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (E1_sort_en) begin
                        state     <= MERGE;
                        topk_busy <= 1'b1;
                        last_q    <= E1_last_sort;
                        p_o       <= '0;
                        p_l       <= '0;
                        p_h       <= '0;
                        k         <= '0;
                        for (int i = 0; i < 5; i++) begin
                            old_q[i] <= held[i];
                            lst_l[i] <= globalize(in_l[i], line_num);
                            lst_h[i] <= globalize(in_h[i], line_num);
                        end
                    end
                end
                MERGE: begin
                    if (E1_sort_en) err_overrun <= 1'b1;
                    case (sel)
                        SEL_OLD: p_o <= p_o + 3'd1;
                        SEL_L:   p_l <= p_l + 3'd1;
                        default: p_h <= p_h + 3'd1;
                    endcase
                    if (k == 3'd4) begin
                        state     <= IDLE;
                        topk_busy <= 1'b0;
                        if (last_q) begin
                            // Final slot goes straight to the output; held
                            // is re-armed for the next frame in the same edge.
                            for (int i = 0; i < 4; i++) topk_q[i] <= held[i];
                            topk_q[4]  <= sel_entry;
                            topk_valid <= 1'b1;
                            for (int i = 0; i < 5; i++) held[i] <= SENT;
                        end else begin
                            held[4] <= sel_entry;
                        end
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            if (k == 3'(i)) held[i] <= sel_entry;
                        end
                        k <= k + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_e2_merge.sv
// Directed testbench for sort_e2_merge: hand-computed expected results for
// reset, single-line, two-line, tie, overrun, clear and negative-data cases.
module tb_sort_e2_merge;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [23:0] l_in[5];
    logic [23:0] h_in[5];
    logic        en;
    logic        last;
    logic [15:0] cnt;
    logic [23:0] out[5];
    logic        valid;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sort_e2_merge dut (
        .sys_clk         (clk),
        .sys_rst         (rst),
        .sorter_clr      (clr),
        .E1L_sorter_out0 (l_in[0]),
        .E1L_sorter_out1 (l_in[1]),
        .E1L_sorter_out2 (l_in[2]),
        .E1L_sorter_out3 (l_in[3]),
        .E1L_sorter_out4 (l_in[4]),
        .E1H_sorter_out0 (h_in[0]),
        .E1H_sorter_out1 (h_in[1]),
        .E1H_sorter_out2 (h_in[2]),
        .E1H_sorter_out3 (h_in[3]),
        .E1H_sorter_out4 (h_in[4]),
        .E1_sort_en      (en),
        .E1_last_sort    (last),
        .E1_index_counter(cnt),
        .topk_out0       (out[0]),
        .topk_out1       (out[1]),
        .topk_out2       (out[2]),
        .topk_out3       (out[3]),
        .topk_out4       (out[4]),
        .topk_valid      (valid),
        .topk_busy       (busy),
        .err_overrun     (err)
    );

    function automatic logic [23:0] mk(input logic [15:0] idx, input logic [7:0] d);
        return {idx, d};
    endfunction

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse E1_sort_en for one cycle; returns in cycle T+1.
    task automatic fire(input logic is_last, input logic [15:0] counter);
        en   = 1'b1;
        last = is_last;
        cnt  = counter;
        tick();
        en   = 1'b0;
        last = 1'b0;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; en = 1'b0; last = 1'b0; cnt = '0;
        for (int i = 0; i < 5; i++) begin l_in[i] = '0; h_in[i] = '0; end
        tick(); tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (out[i] !== 24'h0) begin
                $display("FAIL reset_out%0d got %h want %h", i, out[i], 24'h0);
                n_fail++;
            end
            n_checks++;
        end
        if ({valid, busy, err} !== 3'b000) begin
            $display("FAIL reset_ctrl got v/b/e=%b want 000", {valid, busy, err});
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_single_last();
        logic [23:0] exp[5];
        l_in[0] = mk(16'd3, 8'h7F);  l_in[1] = mk(16'd0, 8'h50);
        l_in[2] = mk(16'd9, 8'h10);  l_in[3] = mk(16'd1, 8'h00);
        l_in[4] = mk(16'd2, 8'h80);
        h_in[0] = mk(16'd17, 8'h60); h_in[1] = mk(16'd31, 8'h20);
        for (int i = 2; i < 5; i++) h_in[i] = mk(16'd16, 8'h80);
        exp[0] = mk(16'd3, 8'h7F);  exp[1] = mk(16'd17, 8'h60);
        exp[2] = mk(16'd0, 8'h50);  exp[3] = mk(16'd31, 8'h20);
        exp[4] = mk(16'd9, 8'h10);
        fire(1'b1, 16'd1);
        if (busy !== 1'b1) begin
            $display("FAIL single_busy_t1 got %b want 1", busy); n_fail++;
        end
        n_checks++;
        repeat (4) tick();
        if ({valid, busy} !== 2'b01) begin
            $display("FAIL single_t5 got v/b=%b want 01", {valid, busy}); n_fail++;
        end
        n_checks++;
        tick();
        if ({valid, busy} !== 2'b10) begin
            $display("FAIL single_t6 got v/b=%b want 10", {valid, busy}); n_fail++;
        end
        n_checks++;
        for (int i = 0; i < 5; i++) begin
            if (out[i] !== exp[i]) begin
                $display("FAIL single_out%0d got %h want %h", i, out[i], exp[i]); n_fail++;
            end
            n_checks++;
        end
        tick();
        if (valid !== 1'b0 || out[0] !== exp[0]) begin
            $display("FAIL single_hold got v=%b out0=%h want v=0 out0=%h", valid, out[0], exp[0]);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_two_lines();
        for (int i = 0; i < 5; i++) begin
            l_in[i] = mk(16'(i), 8'h10);
            h_in[i] = mk(16'(16 + i), 8'h10);
        end
        fire(1'b0, 16'd1);
        repeat (5) tick();
        if (valid !== 1'b0) begin
            $display("FAIL two_line1_novalid got %b want 0", valid); n_fail++;
        end
        n_checks++;
        l_in[0] = mk(16'd5, 8'h7F);
        for (int i = 1; i < 5; i++) l_in[i] = mk(16'(5 + i), 8'h80);
        for (int i = 0; i < 5; i++) h_in[i] = mk(16'(20 + i), 8'h80);
        fire(1'b1, 16'd2);
        repeat (5) tick();
        if (valid !== 1'b1) begin
            $display("FAIL two_valid got %b want 1", valid); n_fail++;
        end
        n_checks++;
        if (out[0] !== 24'h00257F) begin
            $display("FAIL two_out0 got %h want %h", out[0], 24'h00257F); n_fail++;
        end
        n_checks++;
        for (int i = 1; i < 5; i++) begin
            if (out[i] !== mk(16'(i - 1), 8'h10)) begin
                $display("FAIL two_out%0d got %h want %h", i, out[i], mk(16'(i - 1), 8'h10));
                n_fail++;
            end
            n_checks++;
        end
    endtask

    task automatic test_tie();
        for (int i = 0; i < 5; i++) begin
            l_in[i] = mk(16'(i), 8'h05);
            h_in[i] = mk(16'(16 + i), 8'h05);
        end
        fire(1'b1, 16'd1);
        repeat (5) tick();
        for (int i = 0; i < 5; i++) begin
            if (out[i] !== mk(16'(i), 8'h05)) begin
                $display("FAIL tie_out%0d got %h want %h", i, out[i], mk(16'(i), 8'h05));
                n_fail++;
            end
            n_checks++;
        end
    endtask

    task automatic test_overrun();
        int pulses = 0;
        l_in[0] = mk(16'd3, 8'h7F);  l_in[1] = mk(16'd0, 8'h50);
        l_in[2] = mk(16'd9, 8'h10);  l_in[3] = mk(16'd1, 8'h00);
        l_in[4] = mk(16'd2, 8'h80);
        h_in[0] = mk(16'd17, 8'h60); h_in[1] = mk(16'd31, 8'h20);
        for (int i = 2; i < 5; i++) h_in[i] = mk(16'd16, 8'h80);
        fire(1'b1, 16'd1);
        tick(); tick();
        // Cycle T+3: second strobe with data that would win everything.
        for (int i = 0; i < 5; i++) begin
            l_in[i] = mk(16'(i), 8'h7F);
            h_in[i] = mk(16'(16 + i), 8'h7F);
        end
        fire(1'b1, 16'd9);
        if (err !== 1'b1) begin
            $display("FAIL overrun_set got %b want 1", err); n_fail++;
        end
        n_checks++;
        tick(); tick();
        if (valid !== 1'b1 || out[0] !== mk(16'd3, 8'h7F) || out[4] !== mk(16'd9, 8'h10)) begin
            $display("FAIL overrun_first got v=%b out0=%h out4=%h want v=1 out0=%h out4=%h",
                     valid, out[0], out[4], mk(16'd3, 8'h7F), mk(16'd9, 8'h10));
            n_fail++;
        end
        n_checks++;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (valid === 1'b1) pulses++;
        end
        if (pulses != 0 || out[1] !== mk(16'd17, 8'h60)) begin
            $display("FAIL overrun_dropped got pulses=%0d out1=%h want pulses=0 out1=%h",
                     pulses, out[1], mk(16'd17, 8'h60));
            n_fail++;
        end
        n_checks++;
        if (err !== 1'b1) begin
            $display("FAIL overrun_sticky got %b want 1", err); n_fail++;
        end
        n_checks++;
        do_clear();
        if (err !== 1'b0) begin
            $display("FAIL overrun_clear got %b want 0", err); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_clear_mid();
        int pulses = 0;
        for (int i = 0; i < 5; i++) begin
            l_in[i] = mk(16'(i), 8'h7F);
            h_in[i] = mk(16'(16 + i), 8'h7F);
        end
        fire(1'b1, 16'd3);
        tick();
        do_clear();
        if (busy !== 1'b0 || out[0] !== 24'h0) begin
            $display("FAIL clear_abort got busy=%b out0=%h want 0/000000", busy, out[0]);
            n_fail++;
        end
        n_checks++;
        for (int c = 0; c < 6; c++) begin
            if (valid === 1'b1) pulses++;
            tick();
        end
        if (pulses != 0) begin
            $display("FAIL clear_novalid got pulses=%0d want 0", pulses); n_fail++;
        end
        n_checks++;
        for (int i = 0; i < 5; i++) begin
            l_in[i] = mk(16'(i), 8'h20);
            h_in[i] = mk(16'(16 + i), 8'h80);
        end
        fire(1'b1, 16'd1);
        repeat (5) tick();
        for (int i = 0; i < 5; i++) begin
            if (out[i] !== mk(16'(i), 8'h20)) begin
                $display("FAIL clear_fresh_out%0d got %h want %h", i, out[i], mk(16'(i), 8'h20));
                n_fail++;
            end
            n_checks++;
        end
    endtask

    task automatic test_all_min();
        l_in[0] = mk(16'd4, 8'h81);
        for (int i = 1; i < 5; i++) l_in[i] = mk(16'(i - 1), 8'h80);
        for (int i = 0; i < 5; i++) h_in[i] = mk(16'(16 + i), 8'h80);
        fire(1'b1, 16'd2);
        repeat (4) tick();
        if (valid !== 1'b0) begin
            $display("FAIL min_t5 got valid=%b want 0", valid); n_fail++;
        end
        n_checks++;
        tick();
        if (valid !== 1'b1 || out[0] !== 24'h002481) begin
            $display("FAIL min_t6 got v=%b out0=%h want v=1 out0=%h", valid, out[0], 24'h002481);
            n_fail++;
        end
        n_checks++;
        // Held sentinels tie with the 80 candidates and win as the older list.
        for (int i = 1; i < 5; i++) begin
            if (out[i] !== 24'hFFFF80) begin
                $display("FAIL min_out%0d got %h want %h", i, out[i], 24'hFFFF80); n_fail++;
            end
            n_checks++;
        end
    endtask

    initial begin
        test_reset();
        test_single_last();
        test_two_lines();
        test_tie();
        test_overrun();
        test_clear_mid();
        test_all_min();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
